uart_tx_8n1: RTL and testbench
==============================

# uart_tx_8n1

Serial transmitter that sends one byte per frame in 8N1 format (start bit, 8 data bits LSB first, stop bit) on a single output line. The bit period is a fixed number of system clocks set by a parameter. The block sits under the communications controller, which presents a byte on `data`, raises `start`, and uses `ready` to pace a stream of bytes from its command ROM. It runs on the 50 MHz system clock.

## Interface
- `BAUD`, default 434: bit period in clock cycles (434 = 115200 baud at 50 MHz; 868, 1302, 2604, 5208, 10417, 20833, 41667, 83333, 166667 also used); legal range 2..2^18-1.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rstn`  input  1  reset; asynchronous, active-low.
- `data`  input  8  byte to transmit; sampled only on the accept edge.
- `start`  input  1  transmit request, level-sensitive.
- `ready`  output  1  1 = idle and able to accept a byte; 0 = frame in progress.
- `tx`  output  1  serial line; idles high; registered output, glitch-free.

## Operation
- The block has two states: IDLE and SEND.
- **IDLE:**
  - `ready`=1 and `tx`=1; the bit counters are held at 0.
  - On any rising edge with `start`=1, the block captures `data` into a shift register and moves to SEND.
  - On that same edge, `tx` drives 0 (start bit) and `ready` drives 0.
- **SEND:**
  - The frame is 10 bits: start bit 0, then `data[0]` through `data[7]`, then stop bit 1.
  - A baud counter runs 0..BAUD-1 and wraps. On each wrap, the bit index increments and `tx` takes the next frame bit.
  - The counter width is ceil(log2(BAUD)), and the baud divider runs only in SEND.
  - When the stop bit has lasted BAUD cycles, the block returns to IDLE and `ready` goes to 1.
- Inputs during SEND:
  - `start` is ignored.
  - Changes on `data` do not affect the frame in flight.
- Back-to-back frames:
  - If `start` is still 1 on the first IDLE cycle, the next frame is accepted on that edge.
  - `ready` is therefore high for exactly 1 cycle between continuous frames. The controller holds `start` high across a whole message and relies on this.
- Reset (`rstn`=0), at any time, including mid-frame:
  - The block enters IDLE immediately; no edge is needed.
  - `tx`=1, `ready`=1, all counters and the shift register are cleared.
  - A partial frame is abandoned; it is not completed.
  - After `rstn` rises, a new frame may start on the first clock edge where `start`=1.

## Timing
- E0 is the accept edge (IDLE with `start`=1).
- Start bit: `tx`=0 from E0 to E0+BAUD.
- Data bit k (k=0..7): `tx`=`data[k]` from E0+(k+1)·BAUD to E0+(k+2)·BAUD.
- Stop bit: `tx`=1 from E0+9·BAUD to E0+10·BAUD.
- `ready`=0 from E0 until E0+10·BAUD; it returns to 1 at edge E0+10·BAUD.
- Latency from `start` being sampled high to the start bit on `tx` is 0 cycles after the accept edge.
- Minimum frame-to-frame spacing is 10·BAUD+1 cycles.
- With `UART_TX_PARITY_EN`, add BAUD cycles to the frame length and to the `ready`-low time.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- **Defined:** an even-parity bit (XOR of the 8 data bits captured at E0) is inserted between `data[7]` and the stop bit.
  - The frame becomes 11 bits.
  - The parity bit occupies E0+9·BAUD to E0+10·BAUD; the stop bit follows.
  - `ready` returns to 1 at E0+11·BAUD.
- **Not defined:** 8N1 frame exactly as described above; no parity logic is synthesized.

## Test plan
- Single byte, BAUD=4: `data`=0x55 with a 1-cycle `start` pulse → `tx` sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles long; `ready` low for exactly 40 cycles, then 1.
- Newline byte, BAUD=434: `data`=0x0A → bits 0,0,1,0,1,0,0,0,0,1 at 434-cycle spacing, sampled mid-bit by a reference receiver at 115200 baud with the clock at 50 MHz.
- Continuous `start`=1 with `data` changed to 0x41 during the first frame (first byte 0x0A) → first frame carries 0x0A unchanged; `ready` pulses high for 1 cycle; second frame starts on that edge and carries 0x41.
- Data held mid-frame: change `data` from 0xFF to 0x00 at E0+3·BAUD → transmitted byte is 0xFF.
- Mid-frame reset: assert `rstn`=0 at E0+5·BAUD+2 → `tx`=1 and `ready`=1 immediately with no clock edge; after release with `start`=1, a full new frame starts on the next edge.
- Parity build (`UART_TX_PARITY_EN` defined), `data`=0x07 → parity bit 1 at E0+9·BAUD, stop bit at E0+10·BAUD, `ready` back at 1 at E0+11·BAUD.

Source files
------------

// File: rtl/uart_tx_8n1_if.sv
// Byte handshake between the communications controller and uart_tx_8n1.
// The controller drives data/start; the transmitter answers with ready.
interface uart_tx_8n1_if;
   logic [7:0] data;
   logic       start;
   logic       ready;

   modport master (output data, output start, input ready);
   modport slave  (input data, input start, output ready);
endinterface

// File: rtl/uart_tx_8n1.sv
// 8N1 serial transmitter, bit period BAUD clocks, tx idles high.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_8n1 #(
   parameter int BAUD = 434
) (
   input  logic          clk,
   input  logic          rstn,
   uart_tx_8n1_if.slave  bus,
   output logic          tx
);

   localparam int CW = (BAUD > 1) ? $clog2(BAUD) : 1;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam logic [CW-1:0] CNT_MAX  = CW'(BAUD - 1);
   localparam logic [3:0]    LAST_BIT = 4'(NBITS - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          tx_q, tx_d;
   logic          ready_q, ready_d;
`ifdef UART_TX_PARITY_EN
   logic          par_q, par_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      tx_d    = tx_q;
      ready_d = ready_q;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      if (state_q == IDLE) begin
         cnt_d   = '0;
         bit_d   = '0;
         tx_d    = 1'b1;
         ready_d = 1'b1;
         // Start bit goes out on the accept edge itself.
         if (bus.start) begin
            shreg_d = bus.data;
`ifdef UART_TX_PARITY_EN
            par_d   = ^bus.data;
`endif
            tx_d    = 1'b0;
            ready_d = 1'b0;
            state_d = SEND;
         end
      end else begin
         if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            bit_d = bit_q + 4'd1;
            if (bit_q == LAST_BIT) begin
               state_d = IDLE;
               tx_d    = 1'b1;
               ready_d = 1'b1;
               bit_d   = '0;
               shreg_d = '0;
            end else if (bit_q < 4'd8) begin
               // bit_q 0..7 ends start/data bit; next out is shreg_q[0].
               tx_d    = shreg_q[0];
               shreg_d = {1'b0, shreg_q[7:1]};
`ifdef UART_TX_PARITY_EN
            end else if (bit_q == 4'd8) begin
               tx_d    = par_q;
`endif
            end else begin
               tx_d    = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
         ready_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
         ready_q <= ready_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign tx        = tx_q;
   assign bus.ready = ready_q;

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Self-checking bench for uart_tx_8n1 (BAUD=4 and BAUD=434 instances).
// Honours UART_TX_PARITY_EN to match the parity build.
module tb_uart_tx_8n1;

   localparam int B4   = 4;
   localparam int B434 = 434;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic clk = 1'b0;
   logic rstn;
   logic tx4, tx434;

   always #5 clk = ~clk;

   uart_tx_8n1_if bus4();
   uart_tx_8n1_if bus434();

   uart_tx_8n1 #(.BAUD(B4))   dut4   (.clk(clk), .rstn(rstn), .bus(bus4),   .tx(tx4));
   uart_tx_8n1 #(.BAUD(B434)) dut434 (.clk(clk), .rstn(rstn), .bus(bus434), .tx(tx434));

   int n_chk  = 0;
   int n_fail = 0;

   typedef logic [10:0] frame_t;

   typedef struct {
      logic [7:0] d;
      logic [9:0] seq;        // 8N1 line bits, leftmost transmitted first
      logic       par;
      int         mod_cycle;  // cycle after E0 at which data is changed, -1 = never
      logic [7:0] mod_data;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference frame: index = position on the line, 0 = start bit.
   function automatic frame_t model_frame(input logic [7:0] d);
      frame_t f = '1;
      f[0] = 1'b0;
      for (int k = 0; k < 8; k++) f[k+1] = d[k];
`ifdef UART_TX_PARITY_EN
      f[9] = ^d;
`endif
      f[NB-1] = 1'b1;
      return f;
   endfunction

   function automatic frame_t table_frame(input logic [9:0] seq, input logic par);
      frame_t f = '1;
      for (int i = 0; i < 9; i++) f[i] = seq[9-i];
`ifdef UART_TX_PARITY_EN
      f[9]  = par;
      f[10] = seq[0];
`else
      f[9]  = seq[0];
`endif
      return f;
   endfunction

   // Entered #1 after the accept edge; leaves #1 after E0+NB*B4.
   task automatic check_frame(input string name, input frame_t f, input int mod_cycle,
                              input logic [7:0] mod_data, input bit scramble);
      for (int c = 0; c < NB*B4; c++) begin
         chk($sformatf("%s.tx c%0d", name, c), tx4, f[c/B4]);
         chk($sformatf("%s.ready c%0d", name, c), bus4.ready, 1'b0);
         if (c == mod_cycle) bus4.data = mod_data;
         else if (scramble) bus4.data = 8'($urandom);
         tick();
      end
      chk($sformatf("%s.ready_end", name), bus4.ready, 1'b1);
      chk($sformatf("%s.tx_end", name), tx4, 1'b1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      logic [7:0] rx;
      frame_t     f;

      tbl[0] = '{8'h55, 10'b0101010101, 1'b0, -1,      8'h00};
      tbl[1] = '{8'h0A, 10'b0010100001, 1'b0, -1,      8'h00};
      tbl[2] = '{8'hFF, 10'b0111111111, 1'b0, 3*B4,    8'h00};
      tbl[3] = '{8'h00, 10'b0000000001, 1'b0, -1,      8'h00};
      tbl[4] = '{8'h41, 10'b0100000101, 1'b0, 7,       8'hAA};
      tbl[5] = '{8'h80, 10'b0000000011, 1'b1, -1,      8'h00};
      tbl[6] = '{8'h07, 10'b0111000001, 1'b1, 2*B4+1,  8'hF8};

      rstn         = 1'b0;
      bus4.start   = 1'b0;
      bus4.data    = 8'h00;
      bus434.start = 1'b0;
      bus434.data  = 8'h00;
      repeat (3) tick();
      chk("reset.tx4", tx4, 1'b1);
      chk("reset.ready4", bus4.ready, 1'b1);
      chk("reset.tx434", tx434, 1'b1);
      chk("reset.ready434", bus434.ready, 1'b1);
      rstn = 1'b1;
      tick();
      chk("idle.tx4", tx4, 1'b1);
      chk("idle.ready4", bus4.ready, 1'b1);

      // Table vectors, each a 1-cycle start pulse.
      for (int i = 0; i < 7; i++) begin
         bus4.data  = tbl[i].d;
         bus4.start = 1'b1;
         tick();
         bus4.start = 1'b0;
         check_frame($sformatf("tbl%0d", i), table_frame(tbl[i].seq, tbl[i].par),
                     tbl[i].mod_cycle, tbl[i].mod_data, 1'b0);
         tick();
         chk($sformatf("tbl%0d.idle_tx", i), tx4, 1'b1);
         chk($sformatf("tbl%0d.idle_ready", i), bus4.ready, 1'b1);
      end

      // Back-to-back with start held high; data swapped mid-frame.
      bus4.data  = 8'h0A;
      bus4.start = 1'b1;
      tick();
      check_frame("b2b0", table_frame(10'b0010100001, 1'b0), 2*B4, 8'h41, 1'b0);
      tick();
      bus4.start = 1'b0;
      check_frame("b2b1", table_frame(10'b0100000101, 1'b0), -1, 8'h00, 1'b0);
      tick();

      // Randomized bytes with data churning during each frame.
      for (int n = 0; n < 30; n++) begin
         d          = 8'($urandom);
         bus4.data  = d;
         bus4.start = 1'b1;
         tick();
         bus4.start = 1'b0;
         check_frame($sformatf("rnd%0d_%02h", n, d), model_frame(d), -1, 8'h00, 1'b1);
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
            tick();
            chk($sformatf("rnd%0d.gap_tx", n), tx4, 1'b1);
            chk($sformatf("rnd%0d.gap_ready", n), bus4.ready, 1'b1);
         end
      end

      // Mid-frame asynchronous reset.
      bus4.data  = 8'hC3;
      bus4.start = 1'b1;
      tick();
      bus4.start = 1'b0;
      f = model_frame(8'hC3);
      repeat (5*B4+2) tick();
      chk("mrst.tx_before", tx4, f[5]);
      chk("mrst.ready_before", bus4.ready, 1'b0);
      #2;
      rstn = 1'b0;
      #1;
      chk("mrst.tx_async", tx4, 1'b1);
      chk("mrst.ready_async", bus4.ready, 1'b1);
      #3;
      bus4.data  = 8'h5A;
      bus4.start = 1'b1;
      rstn       = 1'b1;
      tick();
      bus4.start = 1'b0;
      check_frame("mrst.new", model_frame(8'h5A), -1, 8'h00, 1'b0);
      tick();

      // Newline at BAUD=434, recovered by a mid-bit sampling receiver.
      bus434.data  = 8'h0A;
      bus434.start = 1'b1;
      tick();
      bus434.start = 1'b0;
      chk("nl.tx_e0", tx434, 1'b0);
      chk("nl.ready_e0", bus434.ready, 1'b0);
      repeat (B434/2) tick();
      chk("nl.start_bit", tx434, 1'b0);
      rx = '0;
      for (int k = 0; k < 8; k++) begin
         repeat (B434) tick();
         rx[k] = tx434;
      end
      chk("nl.byte", rx, 8'h0A);
`ifdef UART_TX_PARITY_EN
      repeat (B434) tick();
      chk("nl.parity", tx434, ^8'h0A);
`endif
      repeat (B434) tick();
      chk("nl.stop_bit", tx434, 1'b1);
      chk("nl.ready_mid_stop", bus434.ready, 1'b0);
      repeat (B434 - B434/2 - 1) tick();
      chk("nl.ready_last", bus434.ready, 1'b0);
      tick();
      chk("nl.ready_back", bus434.ready, 1'b1);
      chk("nl.tx_idle", tx434, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
